cpu_fsm_ctrl: RTL and testbench
===============================

CPU_FSM_CTRL -- requirements
Module: cpu_fsm_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (all state updates on rising edge) and reset_n (sampled only at rising edge of clk).
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 s  input  1  start the instruction held in IR; sampled in WAIT only.
REQ-005 load  input  1  capture in into IR; honoured in WAIT only.
REQ-006 in  input  16  instruction word.
REQ-007 w  output  1  idle indicator, 1 only in WAIT.
REQ-008 loada, loadb, loadc, loads, write  output  1 each  datapath register enables.
REQ-009 asel, bsel  output  1 each  ALU operand selects; bsel is constant 0.
REQ-010 vsel  output  2  writeback source: 00 mdata, 01 sximm8, 10 pc, 11 C.
REQ-011 readnum, writenum  output  3 each  register-file addresses.
REQ-012 shift, ALUop  output  2 each  shifter and ALU controls.
REQ-013 sximm8, sximm5  output  16 each  sign-extended IR[7:0] and IR[4:0].
REQ-014 illegal  output  1  undefined-opcode flag (see REQ-032).

Function
REQ-015 IR fields SHALL be: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
REQ-016 Supported instructions SHALL be: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. All other opcode/op pairs are illegal.
REQ-017 States SHALL be WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM, plus HALT when REQ-032 applies.
REQ-018 Outputs SHALL be Moore functions of state and IR. Every enable not listed for a state is 0, and readnum/writenum are 000 unless listed.
REQ-019 WAIT: w=1. If s=1, next state is DECODE; otherwise the block stays in WAIT.
REQ-020 If load=1 in WAIT, IR SHALL take in on that edge. With load and s both 1, DECODE SHALL operate on the newly loaded word.
REQ-021 If load=1 in any state other than WAIT, the value SHALL be ignored and IR held.
REQ-022 DECODE SHALL route as follows: MOV imm goes to WRITE_IMM; ADD, CMP and AND go to GET_A; MOV reg and MVN go to GET_B; illegal goes to REQ-032.
REQ-023 WRITE_IMM: write=1, vsel=01, writenum=Rn, then WAIT.
REQ-024 GET_A: loada=1, readnum=Rn, then GET_B.
REQ-025 GET_B: loadb=1, readnum=Rm, then ALU.
REQ-026 ALU: ALUop=op, shift=sh, asel=1 for MOV reg (ALUop=00), asel=0 otherwise. CMP asserts loads=1, loadc=0 and goes to WAIT; all others assert loadc=1 and go to WRITE_REG.
REQ-027 WRITE_REG: write=1, vsel=11, writenum=Rd, then WAIT.
REQ-028 Cycles from the edge sampling s to w=1 SHALL be: MOV imm 3; MOV reg/MVN 5; CMP 5; ADD/AND 6.
REQ-029 In all states other than ALU, shift=sh and ALUop=op SHALL be driven, with no effect on the datapath.

Reset
REQ-030 When reset_n=0 at a rising edge, the block SHALL go to WAIT and clear IR to 0x0000 and illegal to 0, from any state including mid-instruction and HALT. No write pulse is issued in the reset cycle.
REQ-031 The post-reset outputs SHALL be: w=1, all enables 0, vsel=00, readnum=writenum=000, sximm8=sximm5=0x0000.

Configuration
REQ-032 Macro CTRL_ILLEGAL_TRAP_EN SHALL select illegal-opcode handling:
- Defined: DECODE with an illegal instruction goes to HALT, with illegal=1 and w=0 until reset; s and load are ignored in HALT.
- Undefined: DECODE with an illegal instruction returns to WAIT after 1 cycle, with no enables asserted; illegal is tied 0 and the HALT state does not exist.

Verification
REQ-033 MOV imm: load 0xD105, then s -> WRITE_IMM cycle has write=1, vsel=01, writenum=001, sximm8=0x0005; w=1 3 cycles after s.
REQ-034 ADD: IR=0xA148 (ADD R2,R1,R0,LSL#1) -> GET_A readnum=001, GET_B readnum=000, ALU loadc=1 ALUop=00 shift=01, WRITE_REG writenum=010 vsel=11; total 6 cycles.
REQ-035 CMP and MVN:
- IR=0xA900 -> ALU cycle has loads=1, loadc=0, and no write in any cycle; 5 cycles.
- IR=0xB861 -> no loada; ALU ALUop=11; writenum=011; 5 cycles.
REQ-036 load=1 with in=0xFFFF during GET_B of an ADD -> IR unchanged, instruction completes normally.
REQ-037 reset_n=0 during ALU of an ADD -> WAIT next cycle, no write asserted, IR=0x0000.
REQ-038 IR=0xE000 plus s:
- With CTRL_ILLEGAL_TRAP_EN: illegal=1 and w=0 persist for 10 or more cycles with s toggling, until reset.
- Without it: w=1 2 cycles after s, and illegal stays 0.

Source files
------------

// File: rtl/cpu_fsm_ctrl_if.sv
// Bus bundle between the instruction controller and whatever drives and consumes it.
// The master side supplies the instruction word and start/load strobes; the slave side returns datapath controls.
interface cpu_fsm_ctrl_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        illegal;

  modport master (
    output s, load, in,
    input  w, loada, loadb, loadc, loads, write, asel, bsel, vsel,
           readnum, writenum, shift, ALUop, sximm8, sximm5, illegal
  );

  modport slave (
    input  s, load, in,
    output w, loada, loadb, loadc, loads, write, asel, bsel, vsel,
           readnum, writenum, shift, ALUop, sximm8, sximm5, illegal
  );
endinterface

// File: rtl/cpu_fsm_ctrl.sv
// Multi-cycle instruction controller: holds IR and sequences datapath enables as Moore outputs.
// Define CTRL_ILLEGAL_TRAP_EN to park in HALT on an undefined opcode instead of returning to WAIT.
module cpu_fsm_ctrl (
  input  logic          clk,
  input  logic          reset_n,
  cpu_fsm_ctrl_if.slave bus
);

  localparam logic [2:0] ST_WAIT      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_GET_A     = 3'd2;
  localparam logic [2:0] ST_GET_B     = 3'd3;
  localparam logic [2:0] ST_ALU       = 3'd4;
  localparam logic [2:0] ST_WRITE_REG = 3'd5;
  localparam logic [2:0] ST_WRITE_IMM = 3'd6;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] ST_HALT      = 3'd7;
`endif

  logic [2:0]  state_reg, state_next;
  logic [15:0] ir_reg, ir_next;

  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_movi, is_movr, is_alu, is_cmp, is_mvn;
  logic       goes_a, goes_b;

  assign opcode  = ir_reg[15:13];
  assign op      = ir_reg[12:11];
  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign goes_a  = is_alu && !is_mvn;
  assign goes_b  = is_movr || is_mvn;

  // IR only listens while idle, so a start in the same cycle decodes the new word.
  assign ir_next = ((state_reg == ST_WAIT) && bus.load) ? bus.in : ir_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_WAIT;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT:      if (bus.s) state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_movi)     state_next = ST_WRITE_IMM;
        else if (goes_a) state_next = ST_GET_A;
        else if (goes_b) state_next = ST_GET_B;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else             state_next = ST_HALT;
`else
        else             state_next = ST_WAIT;
`endif
      end
      ST_GET_A:     state_next = ST_GET_B;
      ST_GET_B:     state_next = ST_ALU;
      ST_ALU:       state_next = is_cmp ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_next = ST_WAIT;
      ST_WRITE_IMM: state_next = ST_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_HALT:      state_next = ST_HALT;
`endif
      default:      state_next = ST_WAIT;
    endcase
  end

  always_comb begin
    bus.w        = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.write    = 1'b0;
    bus.asel     = 1'b0;
    bus.vsel     = 2'b00;
    bus.readnum  = 3'b000;
    bus.writenum = 3'b000;
    case (state_reg)
      ST_WAIT:   bus.w = 1'b1;
      ST_GET_A: begin
        bus.loada   = 1'b1;
        bus.readnum = ir_reg[10:8];
      end
      ST_GET_B: begin
        bus.loadb   = 1'b1;
        bus.readnum = ir_reg[2:0];
      end
      ST_ALU: begin
        bus.asel  = is_movr;
        bus.loads = is_cmp;
        bus.loadc = !is_cmp;
      end
      ST_WRITE_REG: begin
        bus.write    = 1'b1;
        bus.vsel     = 2'b11;
        bus.writenum = ir_reg[7:5];
      end
      ST_WRITE_IMM: begin
        bus.write    = 1'b1;
        bus.vsel     = 2'b01;
        bus.writenum = ir_reg[10:8];
      end
      default: ;
    endcase
  end

  // Shifter/ALU controls follow IR in every state; only the ALU state makes them matter.
  assign bus.shift = ir_reg[4:3];
  assign bus.ALUop = ir_reg[12:11];
  assign bus.bsel  = 1'b0;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal = (state_reg == ST_HALT);
`else
  assign bus.illegal = 1'b0;
`endif

  logic [15:0] sximm8_w, sximm5_w;
  assign sximm8_w[7:0] = ir_reg[7:0];
  assign sximm5_w[4:0] = ir_reg[4:0];

  genvar gi;
  generate
    for (gi = 8; gi < 16; gi++) begin : g_sx8
      assign sximm8_w[gi] = ir_reg[7];
    end
    for (gi = 5; gi < 16; gi++) begin : g_sx5
      assign sximm5_w[gi] = ir_reg[4];
    end
  endgenerate

  assign bus.sximm8 = sximm8_w;
  assign bus.sximm5 = sximm5_w;

endmodule

// File: tb/tb_cpu_fsm_ctrl.sv
// Directed bench for cpu_fsm_ctrl: an instruction-level model predicts every cycle's outputs.
// Build with or without CTRL_ILLEGAL_TRAP_EN to match the design under test.
module tb_cpu_fsm_ctrl;

  typedef struct packed {
    logic        w;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic        illegal;
  } out_t;

  localparam int P_WAIT = 0, P_DEC = 1, P_GA = 2, P_GB = 3, P_ALU = 4, P_WR = 5, P_WI = 6, P_HALT = 7;
  localparam int C_MOVI = 0, C_MOVR = 1, C_ADD = 2, C_CMP = 3, C_AND = 4, C_MVN = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  cpu_fsm_ctrl_if bus ();

  cpu_fsm_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  out_t        exp_cur;
  out_t        obs [0:19];
  logic [15:0] model_ir = 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int cls(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: return C_MOVI;
      5'b110_00: return C_MOVR;
      5'b101_00: return C_ADD;
      5'b101_01: return C_CMP;
      5'b101_10: return C_AND;
      5'b101_11: return C_MVN;
      default:   return C_ILL;
    endcase
  endfunction

  // The sequence of phases an instruction walks through after the start cycle.
  function automatic int phase_at(input int c, input int i);
    int seq[$];
    case (c)
      C_MOVI:        seq = '{P_DEC, P_WI};
      C_ADD, C_AND:  seq = '{P_DEC, P_GA, P_GB, P_ALU, P_WR};
      C_CMP:         seq = '{P_DEC, P_GA, P_GB, P_ALU};
      C_MOVR, C_MVN: seq = '{P_DEC, P_GB, P_ALU, P_WR};
      default:       seq = '{P_DEC};
    endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (c == C_ILL && i >= 1) return P_HALT;
`endif
    return (i < seq.size()) ? seq[i] : P_WAIT;
  endfunction

  function automatic out_t phase_out(input int ph, input logic [15:0] ir);
    out_t e = '0;
    e.shift  = ir[4:3];
    e.ALUop  = ir[12:11];
    e.sximm8 = {{8{ir[7]}}, ir[7:0]};
    e.sximm5 = {{11{ir[4]}}, ir[4:0]};
    case (ph)
      P_WAIT: e.w = 1'b1;
      P_GA:   begin e.loada = 1'b1; e.readnum = ir[10:8]; end
      P_GB:   begin e.loadb = 1'b1; e.readnum = ir[2:0]; end
      P_ALU: begin
        e.asel  = (cls(ir) == C_MOVR);
        e.loads = (cls(ir) == C_CMP);
        e.loadc = (cls(ir) != C_CMP);
      end
      P_WR:   begin e.write = 1'b1; e.vsel = 2'b11; e.writenum = ir[7:5]; end
      P_WI:   begin e.write = 1'b1; e.vsel = 2'b01; e.writenum = ir[10:8]; end
      P_HALT: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t dut_vec();
    out_t d;
    d.w = bus.w; d.loada = bus.loada; d.loadb = bus.loadb; d.loadc = bus.loadc;
    d.loads = bus.loads; d.write = bus.write; d.asel = bus.asel; d.bsel = bus.bsel;
    d.vsel = bus.vsel; d.readnum = bus.readnum; d.writenum = bus.writenum;
    d.shift = bus.shift; d.ALUop = bus.ALUop; d.sximm8 = bus.sximm8;
    d.sximm5 = bus.sximm5; d.illegal = bus.illegal;
    return d;
  endfunction

  always @(negedge clk) begin
    if (chk_en) chk("cycle_outputs", 64'(dut_vec()), 64'(exp_cur));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_cycle(input logic [15:0] word);
    step();
    bus.load = 1'b1; bus.in = word; bus.s = 1'b1;
    exp_cur  = phase_out(P_WAIT, model_ir);
    obs[0]   = dut_vec();
    model_ir = word;
  endtask

  task automatic ph_cycle(input int ph);
    step();
    bus.s = 1'b0; bus.load = 1'b0;
    exp_cur = phase_out(ph, model_ir);
  endtask

  task automatic run_instr(input logic [15:0] word, input bit corrupt, input int exp_lat);
    int lat = 0;
    int c   = cls(word);
    s_cycle(word);
    for (int i = 1; i < 20; i++) begin
      ph_cycle(phase_at(c, i - 1));
      if (corrupt && phase_at(c, i - 1) == P_GB) begin
        bus.load = 1'b1; bus.in = 16'hFFFF;
      end
      obs[i] = dut_vec();
      if (bus.w) begin
        lat = i;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    $display("txn ir=%h class=%0d latency=%0d corrupt=%0d", word, c, lat, corrupt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
    exp_cur = phase_out(P_WAIT, 16'h0000);
    step();
    chk_en = 1'b1;
    step();
    chk("reset_outputs", 64'(dut_vec()), 64'({1'b1, 52'd0}));
    reset_n = 1'b1;
    $display("txn reset");

    ph_cycle(P_WAIT);
    ph_cycle(P_WAIT);

    // MOV R1,#5
    run_instr(16'hD105, 1'b0, 3);
    chk("movi_write", 64'(obs[2].write), 64'd1);
    chk("movi_vsel", 64'(obs[2].vsel), 64'd1);
    chk("movi_writenum", 64'(obs[2].writenum), 64'd1);
    chk("movi_sximm8", 64'(obs[2].sximm8), 64'h0005);

    // ADD R2,R1,R0,LSL#1
    run_instr(16'hA148, 1'b0, 6);
    chk("add_geta_readnum", 64'({obs[2].loada, obs[2].readnum}), 64'({1'b1, 3'b001}));
    chk("add_getb_readnum", 64'({obs[3].loadb, obs[3].readnum}), 64'({1'b1, 3'b000}));
    chk("add_alu", 64'({obs[4].loadc, obs[4].ALUop, obs[4].shift}), 64'({1'b1, 2'b00, 2'b01}));
    chk("add_wr", 64'({obs[5].write, obs[5].writenum, obs[5].vsel}), 64'({1'b1, 3'b010, 2'b11}));

    // CMP R1,R0
    run_instr(16'hA900, 1'b0, 5);
    chk("cmp_alu_flags", 64'({obs[4].loads, obs[4].loadc}), 64'({1'b1, 1'b0}));
    chk("cmp_no_write", 64'(obs[1].write | obs[2].write | obs[3].write | obs[4].write | obs[5].write), 64'd0);

    // MVN R3,R1
    run_instr(16'hB861, 1'b0, 5);
    chk("mvn_no_loada", 64'(obs[1].loada | obs[2].loada | obs[3].loada | obs[4].loada), 64'd0);
    chk("mvn_aluop", 64'(obs[3].ALUop), 64'd3);
    chk("mvn_writenum", 64'(obs[4].writenum), 64'd3);

    // MOV R5,R3,LSR: register move selects A path
    run_instr(16'hC0B3, 1'b0, 5);
    chk("movr_asel", 64'(obs[3].asel), 64'd1);

    // Load without start: IR changes, state stays idle
    step();
    bus.load = 1'b1; bus.in = 16'hB2F9; bus.s = 1'b0;
    exp_cur  = phase_out(P_WAIT, model_ir);
    model_ir = 16'hB2F9;
    ph_cycle(P_WAIT);
    chk("load_only_sximm5", 64'(bus.sximm5), 64'hFFF9);
    chk("load_only_w", 64'(bus.w), 64'd1);
    $display("txn load-only ir=%h", model_ir);

    // AND with negative immediates, then ADD with a load attempt mid-instruction
    run_instr(16'hB2F9, 1'b0, 6);
    run_instr(16'hA148, 1'b1, 6);
    chk("ir_held_sximm8", 64'(bus.sximm8), 64'h0048);

    // Reset during the ALU cycle of an ADD
    s_cycle(16'hA148);
    ph_cycle(P_DEC);
    ph_cycle(P_GA);
    ph_cycle(P_GB);
    ph_cycle(P_ALU);
    reset_n = 1'b0;
    model_ir = 16'h0000;
    ph_cycle(P_WAIT);
    reset_n = 1'b1;
    chk("rst_mid_w", 64'(bus.w), 64'd1);
    chk("rst_mid_write", 64'(bus.write), 64'd0);
    chk("rst_mid_ir", 64'({bus.sximm8, bus.shift}), 64'd0);
    ph_cycle(P_WAIT);
    chk("rst_mid_no_write", 64'(bus.write), 64'd0);
    $display("txn reset during ALU");

`ifdef CTRL_ILLEGAL_TRAP_EN
    s_cycle(16'hE000);
    ph_cycle(P_DEC);
    for (int i = 0; i < 12; i++) begin
      ph_cycle(P_HALT);
      bus.s = i[0]; bus.load = 1'b1; bus.in = 16'hFFFF;
      chk("halt_state", 64'({bus.illegal, bus.w}), 64'({1'b1, 1'b0}));
    end
    $display("txn illegal trap ir=e000");
    ph_cycle(P_HALT);
    reset_n  = 1'b0;
    model_ir = 16'h0000;
    ph_cycle(P_WAIT);
    reset_n = 1'b1;
    chk("halt_reset", 64'({bus.illegal, bus.w}), 64'({1'b0, 1'b1}));
    $display("txn reset out of halt");
`else
    run_instr(16'hE000, 1'b0, 2);
    chk("illegal_flag", 64'(obs[1].illegal | obs[2].illegal), 64'd0);
    run_instr(16'hC800, 1'b0, 2);
`endif

    ph_cycle(P_WAIT);
    ph_cycle(P_WAIT);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
